// File: rtl/ee290_mem_replay_unit_if.sv
// ==========================================================================
// ee290_mem_replay_unit_if : accelerator/cache request-response bus | rev 1.0
// ==========================================================================
`default_nettype none

interface ee290_mem_replay_unit_if;
  logic        acc_req_valid;
  logic        acc_req_ready;
  logic [63:0] acc_req_addr;
  logic [7:0]  acc_req_tag;
  logic        acc_req_wen;
  logic [63:0] acc_req_wdata;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic [7:0]  mem_req_tag;
  logic        mem_req_wen;
  logic [63:0] mem_s1_data;
  logic        mem_s2_nack;

  logic        mem_resp_valid;
  logic        mem_resp_has_data;
  logic [7:0]  mem_resp_tag;
  logic [63:0] mem_resp_data;

  logic        acc_resp_valid;
  logic [7:0]  acc_resp_tag;
  logic [63:0] acc_resp_data;

  logic        busy;

  // master is the replay unit; slave is the accelerator/cache environment
  modport master (
    input  acc_req_valid, acc_req_addr, acc_req_tag, acc_req_wen, acc_req_wdata,
    output acc_req_ready,
    output mem_req_valid, mem_req_addr, mem_req_tag, mem_req_wen, mem_s1_data,
    input  mem_req_ready, mem_s2_nack,
    input  mem_resp_valid, mem_resp_has_data, mem_resp_tag, mem_resp_data,
    output acc_resp_valid, acc_resp_tag, acc_resp_data,
    output busy
  );

  modport slave (
    output acc_req_valid, acc_req_addr, acc_req_tag, acc_req_wen, acc_req_wdata,
    input  acc_req_ready,
    input  mem_req_valid, mem_req_addr, mem_req_tag, mem_req_wen, mem_s1_data,
    output mem_req_ready, mem_s2_nack,
    output mem_resp_valid, mem_resp_has_data, mem_resp_tag, mem_resp_data,
    input  acc_resp_valid, acc_resp_tag, acc_resp_data,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/ee290_mem_replay_unit.sv
// ==========================================================================
// ee290_mem_replay_unit : s1/s2 tracking with nack replay FIFO | rev 1.0
// ==========================================================================
`default_nettype none

module ee290_mem_replay_unit #(
  parameter int DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  ee290_mem_replay_unit_if.master       bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  tag;
    logic        wen;
    logic [63:0] wdata;
  } req_t;

  req_t          fifo_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] fifo_count;
  logic          s1_v;
  logic          s2_v;
  req_t          s1_req;
  req_t          s2_req;
  logic [4:0]    pending_loads;

  logic          fifo_empty;
  logic [CW:0]   occupancy;
  logic          space;
  req_t          acc_req;
  req_t          issue_req;
  logic          issue_valid;
  logic          handshake;
  logic          push;
  logic          pop;
  logic          retire_load;
  logic          resp_fwd;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign fifo_empty  = (fifo_count == '0);
  assign occupancy   = {1'b0, fifo_count} + (CW+1)'(s1_v) + (CW+1)'(s2_v);
  assign space       = (occupancy < (CW+1)'(DEPTH));
  assign acc_req     = {bus.acc_req_addr, bus.acc_req_tag, bus.acc_req_wen, bus.acc_req_wdata};

  // Pending replays always win the port; new traffic waits until they drain.
  assign issue_req   = fifo_empty ? acc_req : fifo_mem[rd_ptr];
  assign issue_valid = !reset && (!fifo_empty || (bus.acc_req_valid && space));
  assign handshake   = issue_valid && bus.mem_req_ready;
  assign pop         = handshake && !fifo_empty;
  assign push        = s2_v && bus.mem_s2_nack;
  assign retire_load = s2_v && !bus.mem_s2_nack && !s2_req.wen;
  assign resp_fwd    = !reset && bus.mem_resp_valid && bus.mem_resp_has_data;

  assign bus.acc_req_ready  = !reset && bus.mem_req_ready && fifo_empty && space;
  assign bus.mem_req_valid  = issue_valid;
  assign bus.mem_req_addr   = issue_req.addr;
  assign bus.mem_req_tag    = issue_req.tag;
  assign bus.mem_req_wen    = issue_req.wen;
  assign bus.mem_s1_data    = (!reset && s1_v) ? s1_req.wdata : 64'd0;
  assign bus.acc_resp_valid = resp_fwd;
  assign bus.acc_resp_tag   = bus.mem_resp_tag;
  assign bus.acc_resp_data  = bus.mem_resp_data;
  assign bus.busy           = !reset && (s1_v || s2_v || !fifo_empty || (pending_loads != 5'd0));

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v          <= 1'b0;
      s2_v          <= 1'b0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_count    <= '0;
      pending_loads <= 5'd0;
    end else begin
      s1_v <= handshake;
      s2_v <= s1_v;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
      case ({retire_load, resp_fwd})
        2'b10:   pending_loads <= pending_loads + 5'd1;
        2'b01:   pending_loads <= pending_loads - 5'd1;
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset; their valid bits qualify them.
  always_ff @(posedge clock) begin
    s1_req <= issue_req;
    s2_req <= s1_req;
    if (push) fifo_mem[wr_ptr] <= s2_req;
  end

endmodule

`default_nettype wire
